// File: rtl/boa_stage_if_pf_if.sv
// IF-stage bundle: program bus, ID-facing prefetch queue head, redirect/stall controls.
// Pure wiring, no latency; q_valid/q_ready and pbus_re/pbus_ready carry the backpressure.
// master = the IF stage, slave = the program memory / ID / forwarding side.
interface boa_stage_if_pf_if;
    logic        pbus_re;
    logic [30:0] pbus_addr;
    logic [31:0] pbus_rdata;
    logic        pbus_ready;
    logic        q_valid;
    logic        q_ready;
    logic [30:0] q_pc;
    logic [31:0] q_insn;
    logic        q_trap;
    logic [3:0]  q_cause;
    logic        id_branch_predict;
    logic [30:0] id_branch_target;
    logic        fw_branch_correct;
    logic [30:0] fw_branch_alt;
    logic        fw_stall_if;

    modport master (
        output pbus_re, pbus_addr, q_valid, q_pc, q_insn, q_trap, q_cause,
        input  pbus_rdata, pbus_ready, q_ready, id_branch_predict, id_branch_target,
               fw_branch_correct, fw_branch_alt, fw_stall_if
    );

    modport slave (
        input  pbus_re, pbus_addr, q_valid, q_pc, q_insn, q_trap, q_cause,
        output pbus_rdata, pbus_ready, q_ready, id_branch_predict, id_branch_target,
               fw_branch_correct, fw_branch_alt, fw_stall_if
    );
endinterface

// File: rtl/boa_stage_if_pf.sv
// IF stage: PC sequencer + DEPTH-entry prefetch queue; optional BOA_IF_PERF_EN adds perf counters.
// Latency: request to queue head is 2 cycles (bus response cycle + registered enqueue).
// Backpressure: no request unless a slot is reserved; q_ready=0 fills the queue and stops fetch.
`ifndef RV_ECAUSE_IALIGN
`define RV_ECAUSE_IALIGN 4'd0
`endif

module boa_stage_if_pf #(
    parameter logic [31:0] ENTRYPOINT = 32'h4000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    boa_stage_if_pf_if.master   bus
`ifdef BOA_IF_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_discarded
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // r_fetch_pc is the next address to request; r_req_pc the address of the request in flight.
    logic [30:0]   r_fetch_pc;
    logic [30:0]   r_req_pc;
    logic          r_inflight;
    logic          r_halt;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [30:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_insn [DEPTH];
    logic          r_q_trap [DEPTH];

    logic          w_redirect;
    logic [30:0]   w_target;
    logic          w_rsp_ok;
    logic          w_retry;
    logic [30:0]   w_pc_base;
    logic [CW-1:0] w_free;
    logic          w_issue;
    logic          w_trap;
    logic          w_q_valid;
    logic          w_pop;
    logic          w_push;

    assign w_redirect = bus.fw_branch_correct | bus.id_branch_predict;
    assign w_target   = bus.fw_branch_correct ? bus.fw_branch_alt : bus.id_branch_target;
    assign w_rsp_ok   = r_inflight & bus.pbus_ready & ~w_redirect;
    assign w_retry    = r_inflight & ~bus.pbus_ready;
    // A dropped response rolls the sequencer back so the same address goes out again.
    assign w_pc_base  = w_retry ? r_req_pc : r_fetch_pc;
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_issue    = rst_n & ~bus.fw_stall_if & ~r_halt & ~w_redirect & ~w_pc_base[0]
                      & (w_free > {{(CW-1){1'b0}}, r_inflight});
    assign w_trap     = rst_n & ~r_halt & ~w_redirect & w_pc_base[0] & ~r_inflight
                      & (w_free != '0);
    assign w_q_valid  = (r_count != '0) & ~bus.fw_branch_correct;
    assign w_pop      = w_q_valid & bus.q_ready;
    assign w_push     = w_rsp_ok | w_trap;

    assign bus.pbus_re   = w_issue;
    assign bus.pbus_addr = w_pc_base;
    assign bus.q_valid   = w_q_valid;
    assign bus.q_pc      = r_q_pc[r_rd_ptr];
    assign bus.q_insn    = r_q_insn[r_rd_ptr];
    assign bus.q_trap    = r_q_trap[r_rd_ptr];
    assign bus.q_cause   = `RV_ECAUSE_IALIGN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= ENTRYPOINT[31:1];
            r_req_pc   <= ENTRYPOINT[31:1];
            r_inflight <= 1'b0;
            r_halt     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (w_redirect) begin
            // A head popped alongside a predict is already consumed; everything else is dropped.
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_halt     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc   <= w_pc_base;
                r_fetch_pc <= w_pc_base + 31'd2;
            end else begin
                r_fetch_pc <= w_pc_base;
            end
            if (w_trap)
                r_halt <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_insn[i] <= '0;
                r_q_trap[i] <= 1'b0;
            end
        end else if (w_push && !w_redirect) begin
            r_q_pc[r_wr_ptr]   <= w_trap ? w_pc_base : r_req_pc;
            r_q_insn[r_wr_ptr] <= w_trap ? 32'h0 : bus.pbus_rdata;
            r_q_trap[r_wr_ptr] <= w_trap;
        end
    end

`ifdef BOA_IF_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;
    logic [32:0] w_fetch_sum;
    logic [32:0] w_disc_sum;
    logic [CW-1:0] w_flushed;
    logic          w_stale_drop;

    assign w_flushed    = w_redirect ? (r_count - {{(CW-1){1'b0}}, w_pop}) : '0;
    assign w_stale_drop = w_redirect & r_inflight & bus.pbus_ready;
    assign w_fetch_sum  = {1'b0, r_perf_fetched} + {32'h0, w_rsp_ok};
    assign w_disc_sum   = {1'b0, r_perf_discarded} + 33'(w_flushed) + {32'h0, w_stale_drop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            r_perf_fetched   <= w_fetch_sum[32] ? 32'hFFFF_FFFF : w_fetch_sum[31:0];
            r_perf_discarded <= w_disc_sum[32]  ? 32'hFFFF_FFFF : w_disc_sum[31:0];
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif
endmodule

// File: doc/boa_stage_if_pf.md
Name: boa_stage_if_pf

Overview:
- Parametrised successor IF stage for the Boa³² pipeline: a PC sequencer with a DEPTH-entry prefetch queue that decouples program-bus fetch from ID consumption.
- Drives the program bus directly and presents instructions to ID over a valid/ready handshake.
- Handles predicted and corrected redirects, discards stale in-flight responses, and raises instruction-misalignment traps.

Parameters:
- ENTRYPOINT, 32'h4000_0000, reset fetch address (bit 0 ignored).
- DEPTH, 4, prefetch queue entries; power of two, 2..16.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous, active-low reset.
- pbus_re  out  1  program read request.
- pbus_addr  out  31 [31:1]  request address.
- pbus_rdata  in  32  read data; valid when pbus_ready=1.
- pbus_ready  in  1  completes the previous cycle's request.
- q_valid  out  1  queue head valid to ID.
- q_ready  in  1  ID accepts head.
- q_pc  out  31 [31:1]  head PC.
- q_insn  out  32  head instruction word.
- q_trap  out  1  head is a trap entry.
- q_cause  out  4  trap cause (`RV_ECAUSE_IALIGN when q_trap).
- id_branch_predict  in  1  ID redirect (predicted taken).
- id_branch_target  in  31  predicted target.
- fw_branch_correct  in  1  misprediction correction; overrides predict.
- fw_branch_alt  in  31  correction target.
- fw_stall_if  in  1  suppress new bus requests.

Behaviour:
- Reset (async, rst_n=0): fetch_pc=ENTRYPOINT, queue empty, no request in flight, halt=0. Outputs: pbus_re=0, q_valid=0, q_trap=0, q_pc/q_insn=0, q_cause=`RV_ECAUSE_IALIGN (constant).
- Bus protocol:
  - Request issued in cycle N when pbus_re=1, with pbus_addr=fetch_pc.
  - Cycle N+1, pbus_ready=1: pbus_rdata is the word at that address; enqueue {pc, insn, trap=0}; fetch_pc+=4 (wraps mod 2^32).
  - Cycle N+1, pbus_ready=0: request dropped; same address re-requested.
  - At most one request outstanding.
- Issue condition: pbus_re = !fw_stall_if && !halt && !redirect_this_cycle && (free_slots > inflight). A completed response always has a slot.
- Queue: FIFO, registered head; q_valid = !empty, except forced 0 in any cycle with fw_branch_correct=1. Pop on q_valid && q_ready. Push and pop in the same cycle is allowed when full.
- Redirect (fw_branch_correct, else id_branch_predict):
  - fetch_pc <= target; halt <= 0.
  - Queue flushed, except that a head popped in the same cycle under id_branch_predict is consumed normally.
  - Any in-flight response is marked stale; its pbus_ready data is ignored, and the address is not re-requested if ready=0.
  - First request to the target issues the next cycle.
- Misalignment: when fetch_pc[1]=1 and a slot is free:
  - enqueue {pc=fetch_pc, insn=0, trap=1} with no bus access;
  - set halt=1 (no further fetch until a redirect).
- fw_stall_if: blocks only new requests. In-flight completions, pops and redirects proceed.
- Reset mid-transfer: in-flight response after reset release is ignored (inflight cleared).
- Full: no issue, and pbus_re=0 while full and nothing in flight.

Optional Feature:
- Macro: BOA_IF_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (responses enqueued, trap entries excluded) and perf_discarded[31:0] (entries flushed plus stale responses dropped). Both counters reset to 0, increment saturating at 32'hFFFF_FFFF, and are visible the cycle after the event.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release with ENTRYPOINT=32'h4000_0000, memory always ready, q_ready=1 -> pbus_addr 0x4000_0000, 0x4000_0004, ...; first q_valid two cycles after first pbus_re; one instruction per cycle thereafter.
- q_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued (PCs 0x4000_0000..0x4000_000C); pbus_re=0 while full; releasing q_ready drains them in order with no gaps.
- pbus_ready=0 on every other response -> each address re-requested once; queued PCs remain strictly sequential, no duplicates.
- fw_branch_correct to 0x4000_0100 with 3 entries queued and one in flight -> q_valid=0 that cycle; the stale response is not enqueued; next head PC=0x4000_0100.
- id_branch_predict to 0x4000_0042 with q_ready=1 -> current head consumed; next entry has q_trap=1, q_pc=0x4000_0042, q_cause=IALIGN; no pbus_re until the next redirect.
- rst_n pulsed low for 1 cycle mid-request with pbus_ready=1 on the following edge -> queue empty and the response ignored; fetch restarts at ENTRYPOINT.
